// File: rtl/variable_precision_accumulator_pkg.sv
// Shared definitions for the variable-precision ALU and accumulator:
// precision modes, accumulator state encoding and error-flag bit positions.
package vp_pkg;

  localparam logic [1:0] VP_MODE_4B  = 2'b00;
  localparam logic [1:0] VP_MODE_8B  = 2'b01;
  localparam logic [1:0] VP_MODE_16B = 2'b10;
  localparam logic [1:0] VP_MODE_ILL = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } vp_state_e;

  localparam int ERR_MODE = 0;  // illegal or mismatched mode
  localparam int ERR_DROP = 1;  // beat arrived while not ready

endpackage

// File: rtl/variable_precision_accumulator_lane_unpack.sv
// Combinational unpack of a packed 64-bit ALU product word into four
// zero-extended ACC_W-bit lanes according to the precision mode.
module vp_lane_unpack
  import vp_pkg::*;
#(
  parameter int ACC_W = 40
) (
  input  logic [63:0]        in_result,
  input  logic [1:0]         in_mode,
  output logic [4*ACC_W-1:0] lanes
);

  // Upper byte of each 16-bit slot never carries a 4-bit-mode product.
  logic unused_bits;
  assign unused_bits = ^{in_result[63:56], in_result[47:40]};

  always_comb begin
    lanes = '0;
    case (in_mode)
      VP_MODE_4B: begin
        for (int i = 0; i < 4; i++) begin
          lanes[i*ACC_W +: ACC_W] = ACC_W'(in_result[16*i +: 8]);
        end
      end
      VP_MODE_8B: begin
        lanes[0 +: ACC_W]     = ACC_W'(in_result[15:0]);
        lanes[ACC_W +: ACC_W] = ACC_W'(in_result[31:16]);
      end
      VP_MODE_16B: lanes[0 +: ACC_W] = ACC_W'(in_result[31:0]);
      default: lanes = '0;
    endcase
  end

endmodule

// File: rtl/variable_precision_accumulator.sv
// Per-lane running-sum accumulator behind variable_precision_alu; emits one
// sum set per vector. Define VPACC_SATURATE_EN to clamp lanes instead of wrapping.
module variable_precision_accumulator
  import vp_pkg::*;
#(
  parameter int ACC_W = 40,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [63:0]        in_result,
  input  logic [1:0]         in_mode,
  input  logic               in_last,
  output logic               in_ready,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [4*ACC_W-1:0] out_sum,
  output logic [1:0]         out_mode,
  output logic [CNT_W-1:0]   out_count,
  output logic [1:0]         err
);

  vp_state_e          state_q, state_d;
  logic [4*ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         mode_q, mode_d;
  logic [1:0]         err_q, err_d;
  logic [4*ACC_W-1:0] lanes;
  logic [4*ACC_W-1:0] add_sum;

  vp_lane_unpack #(.ACC_W(ACC_W)) u_unpack (
    .in_result (in_result),
    .in_mode   (in_mode),
    .lanes     (lanes)
  );

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane_add
`ifdef VPACC_SATURATE_EN
    logic [ACC_W:0] wide_sum;
    assign wide_sum = {1'b0, acc_q[gi*ACC_W +: ACC_W]} + {1'b0, lanes[gi*ACC_W +: ACC_W]};
    assign add_sum[gi*ACC_W +: ACC_W] = wide_sum[ACC_W] ? {ACC_W{1'b1}} : wide_sum[ACC_W-1:0];
`else
    assign add_sum[gi*ACC_W +: ACC_W] = acc_q[gi*ACC_W +: ACC_W] + lanes[gi*ACC_W +: ACC_W];
`endif
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (in_mode != VP_MODE_ILL) begin
            mode_d = in_mode;
            acc_d  = lanes;
            cnt_d  = CNT_W'(1);
          end else begin
            err_d[ERR_MODE] = 1'b1;
          end
          // An illegal last beat still closes the (empty) vector.
          if (in_last)                       state_d = HOLD;
          else if (in_mode != VP_MODE_ILL)   state_d = ACCUM;
        end
      end
      ACCUM: begin
        if (in_valid) begin
          if (in_mode == mode_q) begin
            acc_d = add_sum;
            if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
          end else begin
            err_d[ERR_MODE] = 1'b1;
          end
          if (in_last) state_d = HOLD;
        end
      end
      HOLD: begin
        if (in_valid) err_d[ERR_DROP] = 1'b1;
        if (out_ready) begin
          state_d = IDLE;
          acc_d   = '0;
          cnt_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      mode_q  <= VP_MODE_4B;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      err_q   <= err_d;
    end
  end

  assign in_ready  = (state_q != HOLD);
  assign out_valid = (state_q == HOLD);
  assign out_sum   = acc_q;
  assign out_mode  = mode_q;
  assign out_count = cnt_q;
  assign err       = err_q;

endmodule

// File: tb/tb_variable_precision_accumulator.sv
// Self-checking bench: vector-level reference model, per-cycle compare,
// directed vectors with literal expectations, then randomized traffic.
module tb_variable_precision_accumulator;
  import vp_pkg::*;

  localparam int ACC_W = 40;
  localparam int CNT_W = 16;
  localparam longint unsigned LANE_MAX = (64'd1 << ACC_W) - 64'd1;
  localparam longint unsigned CNT_MAX  = (64'd1 << CNT_W) - 64'd1;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic [63:0]        in_result;
  logic [1:0]         in_mode;
  logic               in_last;
  logic               in_ready;
  logic               out_valid;
  logic               out_ready;
  logic [4*ACC_W-1:0] out_sum;
  logic [1:0]         out_mode;
  logic [CNT_W-1:0]   out_count;
  logic [1:0]         err;

  always #5 clk = ~clk;

  variable_precision_accumulator #(.ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_result (in_result),
    .in_mode   (in_mode),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_mode  (out_mode),
    .out_count (out_count),
    .err       (err)
  );

  int tests = 0;
  int fails = 0;

  function automatic void chk(string name, longint unsigned act, longint unsigned exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic longint unsigned lane_of(int idx);
    return longint'(out_sum[idx*ACC_W +: ACC_W]);
  endfunction

  // Reference model: one open vector (sums/count/mode) plus a "holding result" flag.
  longint unsigned m_sum[4];
  longint unsigned m_lane[4];
  longint unsigned m_count;
  logic [1:0]      m_mode;
  logic [1:0]      m_err;
  bit              m_hold, m_invec, cmp_en;

  function automatic void model_unpack(logic [63:0] d, logic [1:0] m);
    for (int i = 0; i < 4; i++) m_lane[i] = 0;
    if (m == 2'd0)      for (int i = 0; i < 4; i++) m_lane[i] = (d >> (16*i)) & 64'hFF;
    else if (m == 2'd1) for (int i = 0; i < 2; i++) m_lane[i] = (d >> (16*i)) & 64'hFFFF;
    else if (m == 2'd2) m_lane[0] = d & 64'hFFFF_FFFF;
  endfunction

  function automatic longint unsigned lane_add(longint unsigned a, longint unsigned b);
    longint unsigned s = a + b;
`ifdef VPACC_SATURATE_EN
    return (s > LANE_MAX) ? LANE_MAX : s;
`else
    return s & LANE_MAX;
`endif
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) m_sum[i] = 0;
      m_count = 0; m_mode = 2'd0; m_err = 2'd0; m_hold = 0; m_invec = 0;
    end else if (m_hold) begin
      if (in_valid) m_err[1] = 1'b1;
      if (out_ready) begin
        m_hold = 0;
        for (int i = 0; i < 4; i++) m_sum[i] = 0;
        m_count = 0;
      end
    end else if (in_valid) begin
      if (in_mode != 2'd3 && (!m_invec || in_mode == m_mode)) begin
        model_unpack(in_result, in_mode);
        for (int i = 0; i < 4; i++) m_sum[i] = lane_add(m_sum[i], m_lane[i]);
        if (!m_invec) begin
          m_mode  = in_mode;
          m_count = 1;
        end else if (m_count < CNT_MAX) begin
          m_count++;
        end
        m_invec = 1;
      end else begin
        m_err[0] = 1'b1;
      end
      if (in_last) begin
        m_hold  = 1;
        m_invec = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("in_ready", in_ready, !m_hold);
      chk("out_valid", out_valid, m_hold);
      chk("err", err, m_err);
      if (m_hold) begin
        for (int i = 0; i < 4; i++) chk($sformatf("out_sum_lane%0d", i), lane_of(i), m_sum[i]);
        chk("out_count", out_count, m_count);
        if (m_count > 0) chk("out_mode", out_mode, m_mode);
      end
    end
  end

  task automatic cyc(input logic v, input logic [63:0] d, input logic [1:0] m,
                     input logic l, input logic r);
    in_valid = v; in_result = d; in_mode = m; in_last = l; out_ready = r;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  localparam logic [63:0] W4B = 64'h000C_0002_001E_0002;
  localparam logic [63:0] W16 = 64'h0000_0000_FFFE_0001;
  localparam logic [63:0] W8B = 64'h0000_0000_0014_0014;

  logic [1:0]      rmode;
  longint unsigned ovf_exp;

  initial begin
    rst = 1'b1; in_valid = 0; in_result = '0; in_mode = 0; in_last = 0; out_ready = 0;
    @(posedge clk); #1;
    cmp_en = 1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_sum_lane0", lane_of(0), 0);
    chk("rst_out_sum_lane3", lane_of(3), 0);
    chk("rst_out_count", out_count, 0);
    chk("rst_out_mode", out_mode, 0);
    chk("rst_err", err, 0);
    rst = 1'b0;

    // 4-bit mode vector
    cyc(1, W4B, 2'd0, 0, 0);
    cyc(1, W4B, 2'd0, 1, 0);
    chk("m4_valid", out_valid, 1);
    chk("m4_lane0", lane_of(0), 4);
    chk("m4_lane1", lane_of(1), 60);
    chk("m4_lane2", lane_of(2), 4);
    chk("m4_lane3", lane_of(3), 24);
    chk("m4_count", out_count, 2);
    chk("m4_mode", out_mode, 0);
    chk("m4_err", err, 0);
    cyc(0, '0, 2'd0, 0, 1);
    chk("m4_valid_drop", out_valid, 0);

    // 16-bit mode vector, then backpressure on its result
    cyc(1, W16, 2'd2, 0, 0);
    cyc(1, W16, 2'd2, 1, 0);
    chk("m16_lane0", lane_of(0), 64'h1_FFFC_0002);
    chk("m16_lane1", lane_of(1), 0);
    cyc(0, '0, 2'd2, 0, 0);
    cyc(1, 64'h1234, 2'd2, 0, 0);
    cyc(0, '0, 2'd2, 0, 0);
    chk("bp_valid", out_valid, 1);
    chk("bp_in_ready", in_ready, 0);
    chk("bp_err", err, 2'b10);
    chk("bp_lane0", lane_of(0), 64'h1_FFFC_0002);
    chk("bp_count", out_count, 2);
    cyc(0, '0, 2'd2, 0, 1);
    chk("bp_valid_drop", out_valid, 0);

    // Mode mismatch mid-vector
    cyc(1, W8B, 2'd1, 0, 0);
    cyc(1, 64'hFFFF_FFFF, 2'd0, 0, 0);
    cyc(1, W8B, 2'd1, 1, 0);
    chk("mm_lane0", lane_of(0), 40);
    chk("mm_lane1", lane_of(1), 40);
    chk("mm_count", out_count, 2);
    chk("mm_err0", err[0], 1);
    cyc(0, '0, 2'd0, 0, 1);

    // Illegal last beat from IDLE gives an empty result
    cyc(1, 64'hDEAD, 2'd3, 1, 0);
    chk("ill_valid", out_valid, 1);
    chk("ill_count", out_count, 0);
    chk("ill_lane0", lane_of(0), 0);
    cyc(0, '0, 2'd0, 0, 1);

    // Reset mid-vector discards partial sums and errors
    for (int i = 0; i < 3; i++) cyc(1, 64'd7, 2'd2, 0, 0);
    do_reset();
    chk("rmv_err", err, 0);
    cyc(1, 64'd5, 2'd2, 1, 0);
    chk("rmv_lane0", lane_of(0), 5);
    chk("rmv_count", out_count, 1);
    chk("rmv_err2", err, 0);
    cyc(0, '0, 2'd0, 0, 1);

    // Lane overflow: 300 x 0xFFFFFFFF exceeds 2^40
`ifdef VPACC_SATURATE_EN
    ovf_exp = LANE_MAX;
`else
    ovf_exp = 64'd188978560724;
`endif
    for (int i = 0; i < 299; i++) cyc(1, 64'hFFFF_FFFF, 2'd2, 0, 0);
    cyc(1, 64'hFFFF_FFFF, 2'd2, 1, 0);
    chk("ovf_lane0", lane_of(0), ovf_exp);
    chk("ovf_count", out_count, 300);
    cyc(0, '0, 2'd0, 0, 1);

    // Randomized traffic against the model
    rmode = 2'd1;
    for (int n = 0; n < 4000; n++) begin
      logic [1:0] m;
      rst = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 19) == 0) rmode = 2'($urandom_range(0, 2));
      m = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(0, 3)) : rmode;
      cyc(($urandom_range(0, 9) < 6), {$urandom, $urandom}, m,
          ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)));
    end
    rst = 1'b0;
    cyc(0, '0, 2'd0, 0, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/variable_precision_accumulator.md
Name: variable_precision_accumulator

Overview:
- Downstream consumer of variable_precision_alu: takes each packed 64-bit product word plus its precision mode, unpacks the per-lane products and keeps a running unsigned sum per lane.
- Emits one result per vector, i.e. the sum over all beats up to and including the beat flagged last, with a valid/ready handshake towards the writeback/activation stage.
- Fills the dot-product reduction step that follows the multiplier.

Parameters:
- ACC_W, 40, width of each lane accumulator (unsigned, ≥ 8).
- CNT_W, 16, width of the beat counter.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  product beat present (driven from the ALU's valid_out).
- in_result  in  64  packed ALU result.
- in_mode  in  2  precision mode of the beat: 00 4-bit, 01 8-bit, 10 16-bit, 11 illegal.
- in_last  in  1  final beat of the vector.
- in_ready  out  1  beat will be accepted this cycle.
- out_valid  out  1  vector sums available.
- out_ready  in  1  consumer accepts sums.
- out_sum  out  4*ACC_W  lane sums; lane i occupies [i*ACC_W +: ACC_W].
- out_mode  out  2  mode of the completed vector.
- out_count  out  CNT_W  number of beats accumulated.
- err  out  2  sticky flags: [0] illegal or mismatched mode, [1] beat dropped.

Behaviour:
- Reset:
  - state = IDLE; all accumulators, out_sum, out_count and err are 0.
  - out_valid = 0, out_mode = 0, in_ready = 1.
  - Reset asserted mid-vector discards partial sums; it takes priority over every other event.
- Lane unpack, all lanes zero-extended to ACC_W:
  - Mode 00: four lanes, lane i = in_result[16i +: 8].
  - Mode 01: two lanes, lane0 = [15:0], lane1 = [31:16]; lanes 2 and 3 = 0.
  - Mode 10: one lane, lane0 = [31:0]; lanes 1 to 3 = 0.
- A beat is accepted when in_valid && in_ready.
- States:
  - IDLE:
    - On an accepted beat with a legal mode: latch the vector mode, set acc = lanes, count = 1.
    - If in_last is also set, go to HOLD; otherwise go to ACCUM.
  - ACCUM:
    - Each accepted beat adds: acc_i += lane_i, count += 1.
    - count saturates at all-ones.
    - A beat with in_last goes to HOLD, and its own contribution is included in the sums.
  - HOLD:
    - out_valid = 1; out_sum, out_mode and out_count are stable.
    - in_ready = 0.
    - out_valid && out_ready returns to IDLE with accumulators cleared. out_valid falls the cycle after the handshake.
- Latency: a last beat accepted at edge N gives out_valid = 1 from just after edge N. There is no extra pipeline stage.
- Illegal mode (11), or a mode different from the latched vector mode:
  - The beat is not summed and not counted, and err[0] is set.
  - Its in_last is still honoured. In IDLE, an illegal last beat produces an output of zero sums with count 0.
- in_valid while in_ready = 0: the beat is lost and err[1] is set. The ALU has no stall input, so upstream must gate on in_ready.
- err bits clear only on rst.
- Accumulator overflow wraps modulo 2^ACC_W (default build).

Optional Feature:
- Macro: VPACC_SATURATE_EN.
- Defined: each lane add clamps at 2^ACC_W − 1. This is detected via a carry-out of the ACC_W+1-bit sum.
- Undefined: modulo wrap, with no clamp logic present.

Decomposition:
- Shared package vp_pkg holds:
  - Mode constants VP_MODE_4B = 2'b00, VP_MODE_8B = 2'b01, VP_MODE_16B = 2'b10, VP_MODE_ILL = 2'b11.
  - The state encoding IDLE, ACCUM, HOLD.
  - The err bit indices.
  - It is shared with variable_precision_alu.
- Sub-module vp_lane_unpack: purely combinational; turns in_result and in_mode into four ACC_W-bit lanes.

Test Plan:
- Mode 00 vector: two beats of 0x000C_0002_001E_0002, the second with last → lane sums {24, 4, 60, 4} (lane3..lane0), out_count = 2, out_mode = 00, err = 0.
- Mode 10 vector: 0x00000000FFFE0001 twice, second with last → lane0 = 0x1_FFFC_0002, lanes 1 to 3 = 0.
- Backpressure: hold out_ready = 0 for 3 cycles after a completed vector:
  - out_valid stays 1 and in_ready stays 0.
  - A beat presented meanwhile → err[1] = 1 and the sums are unchanged.
  - Raising out_ready → out_valid drops the next cycle.
- Mode mismatch: mode 01 beat of 0x14 on both lanes, then a mode 00 beat, then mode 01 0x14 with last → lanes {20 + 20, 20 + 20} = 40 each, count = 2, err[0] = 1.
- Overflow, ACC_W = 8: mode 01 lane0 = 20 for 13 beats → 4 without VPACC_SATURATE_EN, 255 with it.
- Reset mid-vector: rst after 3 beats, then a single last beat of value 5 → lane0 = 5, count = 1, err = 0.
